rtc_counter: RTL
================

RTC_COUNTER -- requirements
Module: rtc_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per second (legal range >= 2).
REQ-002 SHALL have port clk, input, 1, single system clock; all state on its rising edge.
REQ-003 SHALL have port rstN, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port run, input, 1, timekeeping enable.
REQ-005 SHALL have port setEn, input, 1, set mode; 1 means time is adjusted, not counted.
REQ-006 SHALL have port setSel, input, 2, field select: 0 hour, 1 min, 2 sec, 3 none.
REQ-007 SHALL have ports inc and dec, input, 1 each, adjust requests, level inputs.
REQ-008 SHALL have port mode12h, input, 1; 1 selects 12-hour display.
REQ-009 SHALL have ports hour[4:0], min[5:0], sec[5:0], output, registered displayed time.
REQ-010 SHALL have port pm, output, 1; internal hour >= 12 in either mode.
REQ-011 SHALL have port tick, output, 1, one-cycle pulse per elapsed second.
REQ-012 SHALL have ports almHour[4:0] and almMin[5:0] (24 h), almArm, almAck (inputs), and alarm (output, 1), present in every build.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 while run=1 and setEn=0, and SHALL hold otherwise; tick=1 in the cycle it wraps to 0.
REQ-014 While setEn=1, the prescaler SHALL be cleared to 0, so the first tick after setEn falls comes TICK_DIV cycles later.
REQ-015 On each tick: sec+1; 59->0 carries min+1; 59->0 carries hour+1; 23->0; registered outputs update the cycle after tick.
REQ-016 Internal hour SHALL always be 0..23; in 12 h mode display maps 0->12, 1..12 unchanged, 13..23->1..11; mode12h is combinational onto the output register, 1-cycle latency.
REQ-017 inc/dec SHALL be rising-edge detected internally; a held level yields exactly one step.
REQ-018 In set mode, an inc edge SHALL step the selected field +1 with wrap (hour 23->0, min 59->0); dec SHALL step -1 with wrap (0->23, 0->59).
REQ-019 For setSel=2, an inc or dec edge SHALL clear sec to 0; for setSel=3, edges SHALL be ignored.
REQ-020 Simultaneous inc and dec edges SHALL be ignored; edges while setEn=0 SHALL be ignored.
REQ-021 A field adjust SHALL never carry into another field.

Reset
REQ-022 rstN=0 SHALL immediately force hour=min=sec=0 (display 12 in 12 h mode), pm=0, tick=0, alarm=0, prescaler=0, and edge-detect registers=0, regardless of in-progress counting or set.
REQ-023 After rstN rises, the first tick SHALL occur TICK_DIV cycles after the first cycle with run=1 and setEn=0.

Configuration
REQ-024 Macro RTC_ALARM_EN: when defined, alarm SHALL set on the tick that makes time equal almHour:almMin:00 while almArm=1; it stays set until almAck=1 or almArm=0.
REQ-025 If set and clear coincide in one cycle, set SHALL win; setting time in set mode SHALL never assert alarm.
REQ-026 Without RTC_ALARM_EN, alarm SHALL be tied 0, alarm inputs ignored, no alarm logic synthesised.

Structure
REQ-027 Package rtc_pkg SHALL hold SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, the setSel encoding constants SEL_HOUR/SEL_MIN/SEL_SEC/SEL_NONE, and typedef hms_t (hour, min, sec fields).
REQ-028 Prescaler SHALL be sub-module rtc_prescaler (parameter TICK_DIV; inputs clk, rstN, en, clr; output tick); all other logic stays in rtc_counter.

Verification (TICK_DIV=4)
REQ-029 Reset, run=1 for 240 cycles -> tick every 4th cycle; then 00:01:00.
REQ-030 Set 23:59:58, run for 2 ticks -> 23:59:59 then 00:00:00, pm 1->0.
REQ-031 setEn=1, setSel=0, hour=0, dec pulse -> 23; setSel=1, min=59, inc held 10 cycles -> min 0 only once, hour unchanged; inc and dec together -> no change.
REQ-032 mode12h=1: hour 0 -> 12, pm=0; 12 -> 12, pm=1; 13 -> 1, pm=1; toggling mode leaves internal hour unchanged.
REQ-033 RTC_ALARM_EN, almHour=7, almMin=30, almArm=1, time 07:29:59, one tick -> alarm=1 next cycle; almAck -> 0; repeat with almArm=0 -> alarm stays 0; macro undefined -> alarm always 0.
REQ-034 rstN pulsed low mid-count at 05:06:07 -> outputs 0 in the same cycle, before the next clk edge.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants, time bundle type and 12-hour display mapping for the RTC.
// Imported by the RTC counter, its interface and its testbench.
package rtc_pkg;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    localparam logic [1:0] SEL_HOUR = 2'd0;
    localparam logic [1:0] SEL_MIN  = 2'd1;
    localparam logic [1:0] SEL_SEC  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    // Internal hour is always 0..23; only the displayed value is remapped.
    function automatic logic [4:0] disp_hour(input logic [4:0] h,
                                             input logic       m12);
        if (!m12)
            return h;
        if (h == 5'd0)
            return 5'd12;
        if (h > 5'd12)
            return h - 5'd12;
        return h;
    endfunction

endpackage

// File: rtl/rtc_counter_if.sv
// Signal bundle around the RTC: control and alarm inputs, time and status outputs.
// master drives controls and reads the time; slave is the counter's view.
interface rtc_counter_if;
    import rtc_pkg::*;

    logic       run;
    logic       setEn;
    logic [1:0] setSel;
    logic       inc;
    logic       dec;
    logic       mode12h;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
    logic       tick;
    logic [4:0] almHour;
    logic [5:0] almMin;
    logic       almArm;
    logic       almAck;
    logic       alarm;

    modport master (
        output run, setEn, setSel, inc, dec, mode12h,
        output almHour, almMin, almArm, almAck,
        input  hour, min, sec, pm, tick, alarm
    );

    modport slave (
        input  run, setEn, setSel, inc, dec, mode12h,
        input  almHour, almMin, almArm, almAck,
        output hour, min, sec, pm, tick, alarm
    );

endinterface

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle pulse every TICK_DIV enabled cycles.
// clr has priority and parks the count at zero.
module rtc_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rstN,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en & ~clr & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rtc_counter.sv
// Real-time clock: hh:mm:ss with set mode, 12/24 h display and optional alarm.
// Alarm logic is built only when RTC_ALARM_EN is defined; otherwise alarm is 0.
module rtc_counter
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       run,
    input  logic       setEn,
    input  logic [1:0] setSel,
    input  logic       inc,
    input  logic       dec,
    input  logic       mode12h,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       pm,
    output logic       tick,
    input  logic [4:0] almHour,
    input  logic [5:0] almMin,
    input  logic       almArm,
    input  logic       almAck,
    output logic       alarm
);

    hms_t       t_q, t_d;
    logic       inc_q, dec_q;
    logic [4:0] hour_q;
    logic [5:0] min_q, sec_q;
    logic       pm_q;
    logic       incEdge, decEdge, adjInc, adjDec;

    rtc_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .clk  (clk),
        .rstN (rstN),
        .en   (run & ~setEn),
        .clr  (setEn),
        .tick (tick)
    );

    assign incEdge = inc & ~inc_q;
    assign decEdge = dec & ~dec_q;
    assign adjInc  = setEn & incEdge & ~decEdge;
    assign adjDec  = setEn & decEdge & ~incEdge;

    // tick and adjust are exclusive: the prescaler is held in set mode.
    always_comb begin
        t_d = t_q;
        if (tick) begin
            if (t_q.sec == SEC_MAX) begin
                t_d.sec = '0;
                if (t_q.min == MIN_MAX) begin
                    t_d.min  = '0;
                    t_d.hour = (t_q.hour == HOUR_MAX) ? 5'd0 : t_q.hour + 5'd1;
                end else begin
                    t_d.min = t_q.min + 6'd1;
                end
            end else begin
                t_d.sec = t_q.sec + 6'd1;
            end
        end else if (adjInc || adjDec) begin
            unique case (setSel)
                SEL_HOUR: begin
                    if (adjInc)
                        t_d.hour = (t_q.hour == HOUR_MAX) ? 5'd0 : t_q.hour + 5'd1;
                    else
                        t_d.hour = (t_q.hour == 5'd0) ? HOUR_MAX : t_q.hour - 5'd1;
                end
                SEL_MIN: begin
                    if (adjInc)
                        t_d.min = (t_q.min == MIN_MAX) ? 6'd0 : t_q.min + 6'd1;
                    else
                        t_d.min = (t_q.min == 6'd0) ? MIN_MAX : t_q.min - 6'd1;
                end
                SEL_SEC:  t_d.sec = '0;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            t_q    <= '0;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
            pm_q   <= 1'b0;
        end else begin
            t_q    <= t_d;
            inc_q  <= inc;
            dec_q  <= dec;
            hour_q <= disp_hour(t_d.hour, mode12h);
            min_q  <= t_d.min;
            sec_q  <= t_d.sec;
            pm_q   <= (t_d.hour >= 5'd12);
        end
    end

    assign hour = hour_q;
    assign min  = min_q;
    assign sec  = sec_q;
    assign pm   = pm_q;

`ifdef RTC_ALARM_EN
    logic alarm_q, almSet;

    assign almSet = tick & almArm & (t_d.hour == almHour)
                  & (t_d.min == almMin) & (t_d.sec == 6'd0);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            alarm_q <= 1'b0;
        else if (almSet)
            alarm_q <= 1'b1;
        else if (almAck || !almArm)
            alarm_q <= 1'b0;
    end

    assign alarm = alarm_q;
`else
    logic unused_alm;
    assign unused_alm = ^{almHour, almMin, almArm, almAck};
    assign alarm = 1'b0;
`endif

endmodule
